mux_n_reg: RTL and testbench
============================

Name: mux_n_reg

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer; successor to the single-bit 2:1 logic mux.
- Adds a one-entry valid/ready output register and an auto-scan mode that steps through channels after a programmable dwell.
- Sits between parallel sample sources and a single downstream consumer. Supports manual channel selection or round-robin scanning.

Parameters:
- WIDTH, 8, bit width of each channel and of the output.
- N_CH, 4, number of input channels (>=2).
- DWELL, 4, accepted beats per channel in scan mode (>=1).
- SEL_W, $clog2(N_CH), width of channel index (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  N_CH*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
- sel_in  in  SEL_W  channel select, manual mode.
- mode  in  1  0 = manual, 1 = scan.
- in_valid  in  1  upstream offers a beat this cycle.
- in_ready  out  1  block can accept a beat this cycle.
- y  out  WIDTH  registered selected data.
- y_ch  out  SEL_W  channel index that produced y.
- y_err  out  1  beat used an out-of-range manual select.
- y_valid  out  1  y/y_ch/y_err hold a beat.
- out_ready  in  1  downstream accepts the beat.

Behaviour:
- Reset (async, rst=1): y=0, y_ch=0, y_err=0, y_valid=0, scan pointer=0, dwell counter=0, mode_q=0. All outputs hold these values while rst is high.
- in_ready = !y_valid || out_ready (combinational). No bubble under continuous flow.
- Accept: in_valid && in_ready at a rising edge.
  - On accept, y/y_ch/y_err load with 1-cycle latency and y_valid=1.
  - Else, if out_ready, y_valid=0 and data regs hold.
  - Else everything holds; y is stable while stalled.
- Manual mode (mode_q=0):
  - On accept, y=data_in[sel_in], y_ch=sel_in, y_err=0.
  - If sel_in >= N_CH (non-power-of-2 N_CH): y=0, y_ch=sel_in, y_err=1. The beat is still delivered.
- Scan mode (mode_q=1):
  - sel_in is ignored. On accept, y=data_in[ptr], y_ch=ptr, y_err=0, and the dwell counter increments.
  - When the counter reaches DWELL-1 on an accept, the counter returns to 0 and ptr advances. ptr wraps from N_CH-1 to 0.
  - Non-accept cycles do not advance the counter or ptr.
- Mode register:
  - mode_q <= mode each cycle.
  - A change of mode (mode != mode_q) clears ptr and counter to 0 on that edge.
  - A beat accepted on that same edge uses the new mode and ptr=0, and counter becomes 1 (0 if DWELL=1 and ptr advances to 1).
- Simultaneous accept and drain (y_valid && out_ready && in_valid): the old beat is consumed and the new beat loads; y_valid stays 1.
- Reset mid-stall discards the held beat; no beat is emitted after reset until a new accept.
- State machine (implicit): EMPTY (y_valid=0) <-> FULL (y_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready without accept.
  - FULL -> FULL on accept, or on stall.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release; expect y=0, y_valid=0, in_ready=1; no beats with in_valid=0.
- Manual select: data_in = {8'h44,8'h33,8'h22,8'h11}, out_ready=1, sel_in 0,1,2,3 on consecutive valid cycles. Expect y = 11,22,33,44 one cycle later each; y_ch=0..3; y_valid continuously 1.
- Backpressure: one beat sel=2 accepted, out_ready=0 for 3 cycles with in_valid=1 and sel=1. Expect in_ready=0, y stays 8'h33. Release out_ready; expect next y=8'h22 on the following edge.
- Scan dwell/wrap: mode=1, DWELL=2, in_valid=1, out_ready=1 for 9 beats. Expect y_ch sequence 0,0,1,1,2,2,3,3,0.
- Mode switch mid-scan: after 3 scan beats (ptr=1, counter=1), drop mode to 0 with sel_in=3. Expect y=8'h44, y_ch=3. Return to mode=1; expect y_ch restarts at 0.
- Async reset mid-operation: assert rst between edges while y_valid=1 and stalled. Expect y_valid=0 and y=0 immediately, without waiting for a clock edge; after release, scan restarts at ptr=0.

Source files
------------

// File: rtl/mux_n_reg.sv
// N-channel registered multiplexer with a one-entry valid/ready output stage
// and a round-robin scan mode that dwells DWELL accepted beats per channel.
module mux_n_reg #(
    parameter  int WIDTH = 8,
    parameter  int N_CH  = 4,
    parameter  int DWELL = 4,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH*WIDTH-1:0]   data_in,
    input  logic [SEL_W-1:0]        sel_in,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        y,
    output logic [SEL_W-1:0]        y_ch,
    output logic                    y_err,
    output logic                    y_valid,
    input  logic                    out_ready
);

    // state | meaning
    // EMPTY | output register holds no beat; always ready
    // FULL  | y/y_ch/y_err hold a beat awaiting out_ready

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
    localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W + 1)'(N_CH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] ch [N_CH];
    logic             mode_q;
    logic [SEL_W-1:0] ptr_q, ptr_d, ptr_cur;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;
    logic             accept;
    logic             mode_chg;
    logic [SEL_W-1:0] ch_idx;
    logic [SEL_W-1:0] idx_safe;
    logic             sel_bad;
    logic [WIDTH-1:0] beat_data;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign ch[k] = data_in[k*WIDTH +: WIDTH];
    end

    assign in_ready = (state_q == EMPTY) || out_ready;
    assign accept   = in_valid && in_ready;
    assign y_valid  = (state_q == FULL);

    // A mode change restarts the scan on this very edge, so any beat
    // accepted alongside it already sees ptr=0 and counter=0.
    assign mode_chg = (mode != mode_q);
    assign ptr_cur  = mode_chg ? '0 : ptr_q;
    assign cnt_cur  = mode_chg ? '0 : cnt_q;

    assign ch_idx    = mode ? ptr_cur : sel_in;
    assign sel_bad   = !mode && ({1'b0, sel_in} >= N_CH_EXT);
    assign idx_safe  = sel_bad ? '0 : ch_idx;
    assign beat_data = sel_bad ? '0 : ch[idx_safe];

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (accept) state_d = FULL;
            end
            FULL: begin
                if (accept)         state_d = FULL;
                else if (out_ready) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        ptr_d = ptr_cur;
        cnt_d = cnt_cur;
        if (accept && mode) begin
            if (cnt_cur == LAST_CNT) begin
                cnt_d = '0;
                ptr_d = (ptr_cur == LAST_CH) ? '0 : ptr_cur + 1'b1;
            end else begin
                cnt_d = cnt_cur + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            mode_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Data registers only move on accept so y stays stable while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y     <= '0;
            y_ch  <= '0;
            y_err <= 1'b0;
        end else if (accept) begin
            y     <= beat_data;
            y_ch  <= ch_idx;
            y_err <= sel_bad;
        end
    end

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed bench for mux_n_reg: table of single-cycle vectors plus
// hand-written reset sequences, all expectations computed by hand.
module tb_mux_n_reg;

    localparam int WIDTH = 8;
    localparam int N_CH  = 4;
    localparam int DWELL = 2;
    localparam int SEL_W = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH*WIDTH-1:0] data_in;
    logic [SEL_W-1:0]      sel_in;
    logic                  mode;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      y;
    logic [SEL_W-1:0]      y_ch;
    logic                  y_err;
    logic                  y_valid;
    logic                  out_ready;

    int checks = 0;
    int errors = 0;

    mux_n_reg #(.WIDTH(WIDTH), .N_CH(N_CH), .DWELL(DWELL)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .sel_in    (sel_in),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .y_ch      (y_ch),
        .y_err     (y_err),
        .y_valid   (y_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             mode;
        logic [SEL_W-1:0] sel;
        logic             iv;
        logic             ordy;
        logic             exp_ir;
        logic             exp_v;
        logic [WIDTH-1:0] exp_y;
        logic [SEL_W-1:0] exp_ch;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic m, input logic [SEL_W-1:0] s, input logic iv, input logic ordy,
                       input logic ir, input logic v, input logic [WIDTH-1:0] ey,
                       input logic [SEL_W-1:0] ec);
        vec_t t;
        t.mode = m; t.sel = s; t.iv = iv; t.ordy = ordy;
        t.exp_ir = ir; t.exp_v = v; t.exp_y = ey; t.exp_ch = ec;
        vecs.push_back(t);
    endtask

    // Drive inputs, check in_ready before the edge, then outputs after it.
    task automatic step(input logic m, input logic [SEL_W-1:0] s, input logic iv, input logic ordy,
                        input logic ir, input logic v, input logic [WIDTH-1:0] ey,
                        input logic [SEL_W-1:0] ec, input string tag);
        mode = m; sel_in = s; in_valid = iv; out_ready = ordy;
        #2;
        chk({tag, " in_ready"}, 32'(in_ready), 32'(ir));
        @(posedge clk);
        #1;
        chk({tag, " y_valid"}, 32'(y_valid), 32'(v));
        chk({tag, " y"}, 32'(y), 32'(ey));
        chk({tag, " y_ch"}, 32'(y_ch), 32'(ec));
        chk({tag, " y_err"}, 32'(y_err), 32'd0);
    endtask

    initial begin
        rst = 1'b1; data_in = {8'h44, 8'h33, 8'h22, 8'h11};
        sel_in = '0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

        // idle
        add(0, 0, 0, 1, 1, 0, 8'h00, 0);
        // manual select, continuous flow
        add(0, 0, 1, 1, 1, 1, 8'h11, 0);
        add(0, 1, 1, 1, 1, 1, 8'h22, 1);
        add(0, 2, 1, 1, 1, 1, 8'h33, 2);
        add(0, 3, 1, 1, 1, 1, 8'h44, 3);
        // backpressure
        add(0, 2, 1, 1, 1, 1, 8'h33, 2);
        add(0, 1, 1, 0, 0, 1, 8'h33, 2);
        add(0, 1, 1, 0, 0, 1, 8'h33, 2);
        add(0, 1, 1, 0, 0, 1, 8'h33, 2);
        add(0, 1, 1, 1, 1, 1, 8'h22, 1);
        add(0, 1, 0, 1, 1, 0, 8'h22, 1);
        // scan dwell=2 and wrap, sel_in ignored
        add(1, 3, 1, 1, 1, 1, 8'h11, 0);
        add(1, 3, 1, 1, 1, 1, 8'h11, 0);
        add(1, 3, 1, 1, 1, 1, 8'h22, 1);
        add(1, 3, 1, 1, 1, 1, 8'h22, 1);
        add(1, 3, 1, 1, 1, 1, 8'h33, 2);
        add(1, 3, 1, 1, 1, 1, 8'h33, 2);
        add(1, 3, 1, 1, 1, 1, 8'h44, 3);
        add(1, 3, 1, 1, 1, 1, 8'h44, 3);
        add(1, 3, 1, 1, 1, 1, 8'h11, 0);
        // drain, then mode switch mid-scan
        add(0, 0, 0, 1, 1, 0, 8'h11, 0);
        add(1, 0, 1, 1, 1, 1, 8'h11, 0);
        add(1, 0, 1, 1, 1, 1, 8'h11, 0);
        add(1, 0, 1, 1, 1, 1, 8'h22, 1);
        add(0, 3, 1, 1, 1, 1, 8'h44, 3);
        add(1, 0, 1, 1, 1, 1, 8'h11, 0);
        add(1, 0, 1, 1, 1, 1, 8'h11, 0);
        add(1, 0, 1, 1, 1, 1, 8'h22, 1);

        @(posedge clk); #1;
        chk("reset y_valid", 32'(y_valid), 32'd0);
        chk("reset y", 32'(y), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (vecs[i])
            step(vecs[i].mode, vecs[i].sel, vecs[i].iv, vecs[i].ordy, vecs[i].exp_ir,
                 vecs[i].exp_v, vecs[i].exp_y, vecs[i].exp_ch, $sformatf("vec%0d", i));

        // Stall a held beat (ptr=1, cnt=1 at this point), then reset between edges.
        step(1, 0, 1, 0, 0, 1, 8'h22, 1, "stall");
        #3;
        rst = 1'b1;
        #1;
        chk("async y_valid", 32'(y_valid), 32'd0);
        chk("async y", 32'(y), 32'd0);
        chk("async y_ch", 32'(y_ch), 32'd0);
        chk("async in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(posedge clk); #1;
        chk("held rst y_valid", 32'(y_valid), 32'd0);
        rst = 1'b0;
        step(1, 0, 0, 1, 1, 0, 8'h00, 0, "post-rst idle");
        step(1, 0, 1, 1, 1, 1, 8'h11, 0, "post-rst s0");
        step(1, 0, 1, 1, 1, 1, 8'h11, 0, "post-rst s1");
        step(1, 0, 1, 1, 1, 1, 8'h22, 1, "post-rst s2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
